md_hilo_unit: RTL
=================

Name: md_hilo_unit

Overview:
- Multiply/divide unit with HI/LO registers.
- Consumes the md request fields carried by the EX/MEM pipeline register: md_control, md_signal and the operands.
- Produces the 4-bit busy countdown and the HI/LO values fed back as res_hi/res_lo to EX and to the stall logic.
- Multicycle: starts on a one-cycle request and commits HI/LO after a fixed latency.

Parameters:
- MULT_CYCLES, 5, cycles from an accepted mult/multu start to the HI/LO commit (1..15).
- DIV_CYCLES, 10, cycles from an accepted div/divu start to the HI/LO commit (1..15).

Ports:
- Clk  input  1  system clock, rising edge.
- Reset  input  1  asynchronous active-low reset.
- md_signal  input  1  request strobe, sampled each rising edge.
- md_control  input  3  operation: 0 mult, 1 multu, 2 div, 3 divu, 4 mthi, 5 mtlo, 6/7 reserved.
- md_a  input  32  operand rs.
- md_b  input  32  operand rt.
- busy  output  4  cycles remaining until commit; 0 = idle.
- res_hi  output  32  current HI register.
- res_lo  output  32  current LO register.

Behaviour:
- Reset (async, Reset=0): busy=0, res_hi=0, res_lo=0, pending result=0, state IDLE. Reset mid-operation aborts the operation; the pending result is discarded.
- States: IDLE (busy==0), RUN (busy!=0).
- In IDLE, on a rising edge with md_signal=1:
  - mult/multu: capture {hi,lo} = 64-bit product (signed or unsigned) into the pending register; busy <= MULT_CYCLES; go to RUN.
  - div/divu: pending lo = quotient, hi = remainder (signed: truncate toward zero, remainder takes the sign of the dividend); busy <= DIV_CYCLES; go to RUN.
  - mthi: res_hi <= md_a at the same edge; busy stays 0; res_lo unchanged.
  - mtlo: res_lo <= md_a at the same edge; busy stays 0; res_hi unchanged.
  - Reserved codes: no effect.
- In RUN, each edge busy <= busy-1. On the edge where busy==1: res_hi/res_lo <= pending, busy <= 0, go to IDLE. Result is therefore visible exactly N edges after the start edge (N = MULT_CYCLES or DIV_CYCLES).
- md_signal=1 while busy!=0: ignored entirely, including mthi/mtlo. The hazard unit stalls those requests upstream.
- A request at the same edge as the commit (busy==1): ignored. A new start is accepted only when busy==0 at the sampling edge.
- res_hi/res_lo hold their old values throughout RUN; there are no partial updates.
- Divide by zero (md_b==0): hi <= md_a, lo <= 32'hFFFFFFFF; normal DIV_CYCLES latency.
- Signed overflow (div, md_a=32'h80000000, md_b=32'hFFFFFFFF): lo <= 32'h80000000, hi <= 0.
- Operands are sampled only at the start edge; later changes to md_a/md_b have no effect.
- busy never exceeds max(MULT_CYCLES, DIV_CYCLES); no wrap below 0.

Decomposition:
- Shared package md_pkg holds:
  - md_control encodings (MD_MULT..MD_MTLO)
  - default latency constants
  - BUSY_W=4
- One natural sub-module: md_arith, combinational 64-bit product and quotient/remainder including the divide-by-zero and overflow rules. md_hilo_unit owns the countdown, pending register and HI/LO.

Test Plan:
- Reset then mult, md_a=-3 (32'hFFFFFFFD), md_b=7: busy reads 5,4,3,2,1,0 on successive edges; after 5th edge res_hi=32'hFFFFFFFF, res_lo=32'hFFFFFFEB.
- multu, md_a=md_b=32'hFFFFFFFF: after 5 edges res_hi=32'hFFFFFFFE, res_lo=32'h00000001.
- div, md_a=-7, md_b=2: after 10 edges res_lo=32'hFFFFFFFD (-3), res_hi=32'hFFFFFFFF (-1). divu, 7/0: res_hi=7, res_lo=32'hFFFFFFFF.
- mthi 32'h1234 then mtlo 32'h5678 while idle: each updates next edge, busy stays 0, the other register is unchanged.
- Start mult, then assert mult (md_a=9) and mtlo (32'hAA) at busy=3 and busy=1: both ignored; the final HI/LO equal the first product only.
- Drop Reset at busy=2 of a div: busy, res_hi, res_lo go to 0 immediately; after release, no commit occurs and a new mult starts normally.

Source files
------------

// File: rtl/md_pkg.sv
// Shared definitions for the multiply/divide HI/LO unit: opcodes, latencies, payload types.
package md_pkg;

  localparam int unsigned DATA_W  = 32;
  localparam int unsigned BUSY_W  = 4;
  localparam int unsigned CTRL_W  = 3;

  localparam int unsigned MULT_CYCLES_DEF = 5;
  localparam int unsigned DIV_CYCLES_DEF  = 10;

  localparam logic [CTRL_W-1:0] MD_MULT  = 3'd0;
  localparam logic [CTRL_W-1:0] MD_MULTU = 3'd1;
  localparam logic [CTRL_W-1:0] MD_DIV   = 3'd2;
  localparam logic [CTRL_W-1:0] MD_DIVU  = 3'd3;
  localparam logic [CTRL_W-1:0] MD_MTHI  = 3'd4;
  localparam logic [CTRL_W-1:0] MD_MTLO  = 3'd5;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } md_state_e;

  typedef struct packed {
    logic [DATA_W-1:0] hi;
    logic [DATA_W-1:0] lo;
  } md_result_t;

  // True for the four opcodes that launch a multicycle operation.
  function automatic logic is_start_op(input logic [CTRL_W-1:0] op);
    return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/md_arith.sv
// Combinational 64-bit product and quotient/remainder, including divide-by-zero and overflow rules.
module md_arith
  import md_pkg::*;
(
  input  logic [CTRL_W-1:0] op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output md_result_t        res_c
);

  logic                is_signed;
  logic [2*DATA_W-1:0] a_ext;
  logic [2*DATA_W-1:0] b_ext;
  logic [2*DATA_W-1:0] prod;
  logic                a_neg;
  logic                b_neg;
  logic [DATA_W-1:0]   a_mag;
  logic [DATA_W-1:0]   b_mag;
  logic [DATA_W-1:0]   b_safe;
  logic [DATA_W-1:0]   q_mag;
  logic [DATA_W-1:0]   r_mag;
  logic [DATA_W-1:0]   quot;
  logic [DATA_W-1:0]   rem;
  logic                div_zero;
  logic                div_ovf;

  assign is_signed = (op == MD_MULT) || (op == MD_DIV);

  // Low 64 bits of the product of sign/zero-extended operands give the exact product.
  assign a_ext = is_signed ? {{DATA_W{a[DATA_W-1]}}, a} : {{DATA_W{1'b0}}, a};
  assign b_ext = is_signed ? {{DATA_W{b[DATA_W-1]}}, b} : {{DATA_W{1'b0}}, b};
  assign prod  = a_ext * b_ext;

  // Signed divide through magnitudes: quotient truncates to zero, remainder follows the dividend.
  assign a_neg  = is_signed & a[DATA_W-1];
  assign b_neg  = is_signed & b[DATA_W-1];
  assign a_mag  = a_neg ? (DATA_W'(0) - a) : a;
  assign b_mag  = b_neg ? (DATA_W'(0) - b) : b;
  assign b_safe = div_zero ? DATA_W'(1) : b_mag;
  assign q_mag  = a_mag / b_safe;
  assign r_mag  = a_mag % b_safe;
  assign quot   = (a_neg ^ b_neg) ? (DATA_W'(0) - q_mag) : q_mag;
  assign rem    = a_neg ? (DATA_W'(0) - r_mag) : r_mag;

  assign div_zero = (b == '0);
  assign div_ovf  = is_signed && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);

  always_comb begin
    res_c = '0;
    case (op)
      MD_MULT, MD_MULTU: begin
        res_c.hi = prod[2*DATA_W-1:DATA_W];
        res_c.lo = prod[DATA_W-1:0];
      end
      MD_DIV, MD_DIVU: begin
        if (div_zero) begin
          res_c.hi = a;
          res_c.lo = 32'hFFFF_FFFF;
        end else if (div_ovf) begin
          res_c.hi = '0;
          res_c.lo = 32'h8000_0000;
        end else begin
          res_c.hi = rem;
          res_c.lo = quot;
        end
      end
      default: res_c = '0;
    endcase
  end

endmodule

// File: rtl/md_hilo_unit.sv
// Multicycle multiply/divide unit: busy countdown, pending result and the HI/LO registers.
module md_hilo_unit
  import md_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              md_signal,
  input  logic [CTRL_W-1:0] md_control,
  input  logic [DATA_W-1:0] md_a,
  input  logic [DATA_W-1:0] md_b,
  output logic [BUSY_W-1:0] busy,
  output logic [DATA_W-1:0] res_hi,
  output logic [DATA_W-1:0] res_lo
);

  md_state_e         state_q;
  md_state_e         state_d;
  logic [BUSY_W-1:0] busy_q;
  logic [BUSY_W-1:0] busy_d;
  md_result_t        pend_q;
  md_result_t        pend_d;
  logic [DATA_W-1:0] hi_q;
  logic [DATA_W-1:0] hi_d;
  logic [DATA_W-1:0] lo_q;
  logic [DATA_W-1:0] lo_d;
  md_result_t        arith_res;
  logic              commit;

  md_arith u_arith (
    .op    (md_control),
    .a     (md_a),
    .b     (md_b),
    .res_c (arith_res)
  );

  assign commit = (state_q == ST_RUN) && (busy_q == BUSY_W'(1));

  // State register.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next state: starts only from IDLE, return on the commit edge.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (md_signal && is_start_op(md_control)) state_d = ST_RUN;
      ST_RUN:  if (commit) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Datapath next values; requests while running are dropped, including mthi/mtlo.
  always_comb begin
    busy_d = busy_q;
    pend_d = pend_q;
    hi_d   = hi_q;
    lo_d   = lo_q;
    case (state_q)
      ST_IDLE: begin
        if (md_signal) begin
          case (md_control)
            MD_MULT, MD_MULTU: begin
              pend_d = arith_res;
              busy_d = BUSY_W'(MULT_CYCLES);
            end
            MD_DIV, MD_DIVU: begin
              pend_d = arith_res;
              busy_d = BUSY_W'(DIV_CYCLES);
            end
            MD_MTHI: hi_d = md_a;
            MD_MTLO: lo_d = md_a;
            default: ;
          endcase
        end
      end
      ST_RUN: begin
        busy_d = busy_q - BUSY_W'(1);
        if (commit) begin
          busy_d = '0;
          hi_d   = pend_q.hi;
          lo_d   = pend_q.lo;
        end
      end
      default: busy_d = '0;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      busy_q <= '0;
      pend_q <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
    end else begin
      busy_q <= busy_d;
      pend_q <= pend_d;
      hi_q   <= hi_d;
      lo_q   <= lo_d;
    end
  end

  assign busy   = busy_q;
  assign res_hi = hi_q;
  assign res_lo = lo_q;

endmodule
